// File: rtl/trig_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trig_tx_pkg
// Brief    : Shared constants for the VFAT-side S-bit trigger transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package trig_tx_pkg;

    localparam int FRAME_SLOTS = 8;

    localparam logic [1:0] MODE_SBITS = 2'd0;
    localparam logic [1:0] MODE_PRBS  = 2'd1;
    localparam logic [1:0] MODE_WALK  = 2'd2;
    localparam logic [1:0] MODE_ZERO  = 2'd3;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PREAMBLE = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;

    localparam logic [6:0] PRBS7_SEED = 7'h7F;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs7_gen.sv
`default_nettype none
// ============================================================================
// Module   : prbs7_gen
// Brief    : x^7+x^6+1 PRBS generator producing 1 or 2 bits per advance.
// Revision : 1.0 - initial release
// ============================================================================
module prbs7_gen
    import trig_tx_pkg::*;
#(
    parameter logic [6:0] SEED = PRBS7_SEED,
    parameter int         STEP = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       advance,
    output logic [1:0] bits
);

    logic [6:0] r_state;
    logic [6:0] w_state_next;
    logic [6:0] w_s1;
    logic       w_b0;

    // bits[1] is always the earlier bit in time; bits[0] is the second bit of a 2-step advance
    assign w_b0 = r_state[6] ^ r_state[5];
    assign w_s1 = {r_state[5:0], w_b0};

    generate
        if (STEP == 2) begin : g_step2
            logic       w_b1;
            logic [6:0] w_s2;
            assign w_b1         = w_s1[6] ^ w_s1[5];
            assign w_s2         = {w_s1[5:0], w_b1};
            assign w_state_next = w_s2;
            assign bits         = {w_b0, w_b1};
        end else begin : g_step1
            assign w_state_next = w_s1;
            assign bits         = {w_b0, 1'b0};
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= SEED;
        end else if (advance) begin
            r_state <= w_state_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sbit_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sbit_frame_serializer
// Brief    : Serializes one S-bit word per BX into 8-slot frames with SOT.
// Revision : 1.0 - initial release
// ============================================================================
module sbit_frame_serializer
    import trig_tx_pkg::*;
#(
    parameter int DDR             = 0,
    parameter int MXIO            = 8,
    parameter int MXSBITS         = 64 + 64 * DDR,
    parameter int WORD_SIZE       = MXSBITS / MXIO,
    parameter int PREAMBLE_FRAMES = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic [2:0]         sot_offset,
    input  logic [MXSBITS-1:0] sbits,
    input  logic               sbits_valid,
    output logic               sbits_ready,
    output logic [MXIO-1:0]    d0,
    output logic [MXIO-1:0]    d1,
    output logic               sot,
    output logic               running,
    output logic               underrun,
    output logic [15:0]        underrun_cnt
);

    localparam int                  c_STEP      = (DDR != 0) ? 2 : 1;
    localparam logic                c_DDR_EN    = (DDR != 0);
    localparam int                  c_WALK_W    = $clog2(MXSBITS);
    localparam logic [c_WALK_W-1:0] c_WALK_LAST = c_WALK_W'(MXSBITS - 1);
    localparam logic [11:0]         c_PRE_LAST  = 12'(PREAMBLE_FRAMES - 1);
    localparam logic [2:0]          c_LAST_SLOT = 3'(FRAME_SLOTS - 1);

    logic [1:0]          r_state;
    logic [2:0]          r_slot;
    logic [11:0]         r_pre_cnt;
    logic                r_stop;
    logic [2:0]          r_sot_ofs;
    logic                r_frame_prbs;
    logic [c_WALK_W-1:0] r_walk_idx;
    logic [WORD_SIZE-1:0] r_shift [MXIO];
    logic [MXIO-1:0]     r_d0;
    logic [MXIO-1:0]     r_d1;
    logic                r_sot;
    logic                r_running;
    logic                r_ready;
    logic                r_underrun;
    logic [15:0]         r_underrun_cnt;

    logic [1:0]          w_state_next;
    logic [2:0]          w_slot_next;
    logic                w_frame_end;
    logic                w_load;
    logic                w_stop;
    logic                w_out_on;
    logic                w_next_run;
    logic                w_next_prbs;
    logic                w_frame_prbs_next;
    logic                w_accept;
    logic                w_underrun_next;
    logic [2:0]          w_ofs_next;
    logic [MXSBITS-1:0]  w_word;
    logic [1:0]          w_prbs_bits;
    logic [WORD_SIZE-1:0] w_src        [MXIO];
    logic [WORD_SIZE-1:0] w_shift_next [MXIO];
    logic [MXIO-1:0]     w_d0_next;
    logic [MXIO-1:0]     w_d1_next;

    assign w_frame_end = (r_state != ST_IDLE) && (r_slot == c_LAST_SLOT);
    assign w_stop      = r_stop || !enable;
    assign w_load      = ((r_state == ST_IDLE) && enable) || w_frame_end;
    assign w_slot_next = (r_state == ST_IDLE) ? 3'd0 : r_slot + 3'd1;
    assign w_out_on    = (w_state_next != ST_IDLE);
    assign w_next_run  = w_frame_end && (w_state_next == ST_RUN);
    assign w_next_prbs = w_next_run && (mode == MODE_PRBS);
    assign w_accept    = r_ready && sbits_valid;
    assign w_ofs_next  = w_load ? sot_offset : r_sot_ofs;

    // A PRBS frame keeps pulling from the generator until its last slot
    assign w_frame_prbs_next = w_load ? w_next_prbs : r_frame_prbs;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_next = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (w_frame_end) begin
                    if (w_stop) begin
                        w_state_next = ST_IDLE;
                    end else if (r_pre_cnt == c_PRE_LAST) begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_frame_end && w_stop) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_word          = '0;
        w_underrun_next = 1'b0;
        if (w_next_run) begin
            case (mode)
                MODE_SBITS: begin
                    if (w_accept) begin
                        w_word = sbits;
                    end else begin
                        w_underrun_next = 1'b1;
                    end
                end
                MODE_WALK: w_word[r_walk_idx] = 1'b1;
                default:   w_word = '0;
            endcase
        end
    end

    prbs7_gen #(
        .SEED (PRBS7_SEED),
        .STEP (c_STEP)
    ) u_prbs (
        .clock   (clock),
        .reset_n (reset_n),
        .advance (w_frame_prbs_next),
        .bits    (w_prbs_bits)
    );

    // Each pin streams its own WORD_SIZE slice MSB first; PRBS overrides all pins
    always_comb begin
        w_d0_next = '0;
        w_d1_next = '0;
        for (int p = 0; p < MXIO; p++) begin
            w_src[p]        = w_load ? w_word[p*WORD_SIZE +: WORD_SIZE] : r_shift[p];
            w_shift_next[p] = w_src[p] << c_STEP;
            if (w_frame_prbs_next) begin
                w_d0_next[p] = w_prbs_bits[1];
                w_d1_next[p] = w_prbs_bits[0] & c_DDR_EN;
            end else begin
                w_d0_next[p] = w_src[p][WORD_SIZE-1];
                w_d1_next[p] = w_src[p][WORD_SIZE-2] & c_DDR_EN;
            end
            if (!w_out_on) begin
                w_shift_next[p] = '0;
                w_d0_next[p]    = 1'b0;
                w_d1_next[p]    = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_slot         <= 3'd0;
            r_pre_cnt      <= 12'd0;
            r_stop         <= 1'b0;
            r_sot_ofs      <= 3'd0;
            r_frame_prbs   <= 1'b0;
            r_walk_idx     <= '0;
            r_shift        <= '{default: '0};
            r_d0           <= '0;
            r_d1           <= '0;
            r_sot          <= 1'b0;
            r_running      <= 1'b0;
            r_ready        <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= 16'd0;
        end else begin
            r_state      <= w_state_next;
            r_slot       <= w_slot_next;
            r_stop       <= w_out_on && w_stop;
            r_sot_ofs    <= w_ofs_next;
            r_frame_prbs <= w_frame_prbs_next;
            r_shift      <= w_shift_next;
            r_d0         <= w_d0_next;
            r_d1         <= w_d1_next;
            r_sot        <= w_out_on && (w_slot_next == w_ofs_next);
            r_running    <= (w_state_next == ST_RUN);
            r_underrun   <= w_underrun_next;

            if (r_state == ST_IDLE) begin
                r_pre_cnt <= 12'd0;
            end else if (w_frame_end && (r_state == ST_PREAMBLE)) begin
                r_pre_cnt <= r_pre_cnt + 12'd1;
            end

            if (w_next_run && (mode == MODE_WALK)) begin
                r_walk_idx <= (r_walk_idx == c_WALK_LAST) ? '0 : r_walk_idx + 1'b1;
            end

            // Ready is decided one slot early so the handshake lands in slot 7
            r_ready <= (r_state != ST_IDLE) && (r_slot == c_LAST_SLOT - 3'd1) &&
                       (mode == MODE_SBITS) && !w_stop &&
                       ((r_state == ST_RUN) ||
                        ((r_state == ST_PREAMBLE) && (r_pre_cnt == c_PRE_LAST)));

            if (w_underrun_next) begin
                r_underrun_cnt <= sat_inc16(r_underrun_cnt);
            end
        end
    end

    assign d0           = r_d0;
    assign d1           = r_d1;
    assign sot          = r_sot;
    assign running      = r_running;
    assign sbits_ready  = r_ready;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_underrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sbit_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sbit_frame_serializer
// Brief    : Directed self-checking bench for sbit_frame_serializer (SDR + DDR).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sbit_frame_serializer;

    localparam int PRE = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  mode;
    logic [2:0]  sot_offset;
    logic [63:0] sbits;
    logic        sbits_valid;
    logic        sbits_ready;
    logic [7:0]  d0, d1;
    logic        sot, running, underrun;
    logic [15:0] underrun_cnt;

    logic         en_ddr;
    logic [1:0]   dd_mode = 2'd1;
    logic [2:0]   dd_ofs = 3'd0;
    logic [127:0] dd_sbits = '0;
    logic         dd_valid = 1'b0;
    logic         dd_ready, dd_sot, dd_running, dd_underrun;
    logic [7:0]   dd_d0, dd_d1;
    logic [15:0]  dd_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    sbit_frame_serializer #(
        .DDR (0), .MXIO (8), .PREAMBLE_FRAMES (PRE)
    ) dut (
        .clock (clock), .reset_n (reset_n), .enable (enable), .mode (mode),
        .sot_offset (sot_offset), .sbits (sbits), .sbits_valid (sbits_valid),
        .sbits_ready (sbits_ready), .d0 (d0), .d1 (d1), .sot (sot),
        .running (running), .underrun (underrun), .underrun_cnt (underrun_cnt)
    );

    sbit_frame_serializer #(
        .DDR (1), .MXIO (8), .PREAMBLE_FRAMES (PRE)
    ) dut_ddr (
        .clock (clock), .reset_n (reset_n), .enable (en_ddr), .mode (dd_mode),
        .sot_offset (dd_ofs), .sbits (dd_sbits), .sbits_valid (dd_valid),
        .sbits_ready (dd_ready), .d0 (dd_d0), .d1 (dd_d1), .sot (dd_sot),
        .running (dd_running), .underrun (dd_underrun), .underrun_cnt (dd_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic prbs_next(inout logic [6:0] s, output logic b);
        b = s[6] ^ s[5];
        s = {s[5:0], b};
    endtask

    function automatic logic [7:0] sdr_slot(input logic [63:0] w, input int k);
        logic [7:0] r;
        for (int p = 0; p < 8; p++) r[p] = w[p*8 + 7 - k];
        return r;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] cap;
        logic [63:0] word;
        logic [63:0] exp;
        logic [7:0]  pin0;
        logic [6:0]  m_sdr;
        logic [6:0]  m_ddr;
        logic        b;
        logic        b2;

        reset_n = 1'b0; enable = 1'b0; mode = 2'd0; sot_offset = 3'd0;
        sbits = '0; sbits_valid = 1'b0; en_ddr = 1'b0;
        m_sdr = 7'h7F; m_ddr = 7'h7F;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_outputs", {d0, d1, sot, running, sbits_ready, underrun}, '0);
        end
        check("idle_cnt", underrun_cnt, 0);

        // Preamble: 4 frames of SOT with zero data
        sbits = 64'h0123456789ABCDEF; word = sbits; sbits_valid = 1'b1; enable = 1'b1;
        tick();
        for (int c = 0; c < 32; c++) begin
            check("pre_sot", sot, (c % 8 == 0));
            check("pre_d0", d0, 0);
            check("pre_running", running, 0);
            check("pre_ready", sbits_ready, (c == 31));
            tick();
        end

        // First RUN frame carries the accepted word
        pin0 = 8'hEF; cap = '0;
        check("sdr_d1", d1, 0);
        for (int k = 0; k < 8; k++) begin
            check("run_running", running, 1);
            check("run_sot", sot, (k == 0));
            check("map_pin0", d0[0], pin0[7-k]);
            check("map_all", d0, sdr_slot(word, k));
            check("run_ready", sbits_ready, (k == 7));
            for (int p = 0; p < 8; p++) cap[p*8 + 7 - k] = d0[p];
            if (k == 7) sbits_valid = 1'b0;
            tick();
        end
        check("recover_word", cap, word);

        // Missing word -> zero frame and one underrun pulse
        for (int k = 0; k < 8; k++) begin
            check("under_d0", d0, 0);
            check("under_pulse", underrun, (k == 0));
            check("under_sot", sot, (k == 0));
            if (k == 7) begin
                check("under_cnt", underrun_cnt, 1);
                sbits = 64'hFEDCBA9876543210; word = sbits; sbits_valid = 1'b1; sot_offset = 3'd3;
            end
            tick();
        end

        // SOT moved to slot 3; data timing unchanged
        pin0 = 8'h10; cap = '0;
        for (int k = 0; k < 8; k++) begin
            check("ofs_sot", sot, (k == 3));
            check("ofs_pin0", d0[0], pin0[7-k]);
            check("ofs_map", d0, sdr_slot(word, k));
            check("ofs_underrun", underrun, 0);
            for (int p = 0; p < 8; p++) cap[p*8 + 7 - k] = d0[p];
            if (k == 7) begin
                mode = 2'd2; sot_offset = 3'd0; sbits_valid = 1'b0;
            end
            tick();
        end
        check("ofs_word", cap, word);

        // Walking one over 65 frames
        for (int n = 0; n < 65; n++) begin
            cap = '0;
            for (int k = 0; k < 8; k++) begin
                for (int p = 0; p < 8; p++) cap[p*8 + 7 - k] = d0[p];
                if (n == 64 && k == 7) mode = 2'd1;
                tick();
            end
            if (n == 0 || n == 1 || n == 63 || n == 64) begin
                exp = 64'd1 << (n % 64);
                check($sformatf("walk_%0d", n), cap, exp);
            end
        end

        // PRBS-7 on all pins; stop mid-way through the last frame
        for (int f = 0; f < 21; f++) begin
            for (int k = 0; k < 8; k++) begin
                prbs_next(m_sdr, b);
                check("prbs_d0", d0, {8{b}});
                check("prbs_running", running, 1);
                if (f == 20 && k == 3) enable = 1'b0;
                tick();
            end
        end
        for (int i = 0; i < 16; i++) begin
            check("stop_idle", {d0, sot, running}, 0);
            tick();
        end
        check("cnt_hold", underrun_cnt, 1);

        // Re-enable in mode 3 replays the full preamble
        mode = 2'd3; enable = 1'b1;
        tick();
        for (int c = 0; c < 40; c++) begin
            check("m3_running", running, (c >= 32));
            check("m3_sot", sot, (c % 8 == 0));
            check("m3_d0", d0, 0);
            tick();
        end
        enable = 1'b0;

        // DDR instance: d0/d1 interleave follows the same PRBS sequence
        en_ddr = 1'b1;
        tick();
        for (int c = 0; c < 32; c++) begin
            check("ddr_pre", {dd_d0, dd_d1, dd_running}, 0);
            tick();
        end
        for (int c = 0; c < 32; c++) begin
            prbs_next(m_ddr, b);
            prbs_next(m_ddr, b2);
            check("ddr_pair", {dd_d0, dd_d1}, {{8{b}}, {8{b2}}});
            check("ddr_running", dd_running, 1);
            tick();
        end

        // Asynchronous reset in the middle of a frame
        #3 reset_n = 1'b0;
        #1;
        check("rst_ddr_outs", {dd_d0, dd_d1, dd_sot, dd_running, dd_ready}, 0);
        check("rst_cnt", underrun_cnt, 0);
        en_ddr = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("post_rst_idle", {d0, sot, running, dd_d0, dd_d1, dd_sot, dd_running}, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
